// File: rtl/approx_mon_pkg.sv
// Shared types and default widths for the approximate-adder error monitor.
package approx_mon_pkg;

  localparam int DEF_WIDTH        = 16;
  localparam int DEF_SAMPLES_LOG2 = 10;
  localparam int RES_W            = DEF_WIDTH + 1;
  localparam int SUM_W            = RES_W + DEF_SAMPLES_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/approx_err_monitor_err_distance.sv
// Combinational error distance |(IN1 + IN2) - APPROX| for one approximate-adder sample.
module err_distance
  import approx_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  input  logic [WIDTH:0]   APPROX,
  output logic [WIDTH:0]   ed
);

  logic [WIDTH:0]          exact;
  logic signed [WIDTH+1:0] diff;

  assign exact = {1'b0, IN1} + {1'b0, IN2};
  assign diff  = $signed({1'b0, exact}) - $signed({1'b0, APPROX});

  // |diff| never exceeds 2^(WIDTH+1)-1, so negating the low bits alone is exact.
  assign ed = diff[WIDTH+1] ? (~diff[WIDTH:0] + 1'b1) : diff[WIDTH:0];

endmodule

// File: rtl/approx_err_monitor.sv
// Streaming error statistics (sum/mean/max ED, error count) over 2^SAMPLES_LOG2 samples.
module approx_err_monitor
  import approx_mon_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int SAMPLES_LOG2 = DEF_SAMPLES_LOG2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               IN1,
  input  logic [WIDTH-1:0]               IN2,
  input  logic [WIDTH:0]                 APPROX,
  output logic                           busy,
  output logic                           done,
  output logic [WIDTH:0]                 mae,
  output logic [WIDTH:0]                 max_ed,
  output logic [SAMPLES_LOG2:0]          err_cnt,
  output logic [WIDTH+SAMPLES_LOG2:0]    sum_ed,
  output state_t                         dbg_state
);

  localparam int RW = WIDTH + 1;
  localparam int SW = RW + SAMPLES_LOG2;
  localparam int CW = SAMPLES_LOG2 + 1;
  localparam logic [CW-1:0] N_SAMPLES = {1'b1, {SAMPLES_LOG2{1'b0}}};

  // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on registered state, never on in_valid.

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            s1_valid;
  logic [RW-1:0]   s1_ed;
  logic [RW-1:0]   ed;
  logic            done_q;
  logic            start_ok;
  logic            xfer;

  err_distance #(.WIDTH(WIDTH)) u_ed (
    .IN1    (IN1),
    .IN2    (IN2),
    .APPROX (APPROX),
    .ed     (ed)
  );

  // The first DONE cycle (done high) refuses start so results are seen at least once.
  assign start_ok = start && ((state == ST_IDLE) || ((state == ST_DONE) && !done_q));
  assign in_ready = (state == ST_RUN) && (cnt != N_SAMPLES);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_RUN;
      ST_RUN:   if (cnt == N_SAMPLES) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!s1_valid) state_nxt = ST_DONE;
      ST_DONE:  if (start_ok) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == ST_DRAIN) && !s1_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      s1_valid <= 1'b0;
      s1_ed    <= '0;
    end else begin
      if (start_ok) begin
        cnt      <= '0;
        s1_valid <= 1'b0;
      end else begin
        if (xfer) cnt <= cnt + 1'b1;
        s1_valid <= xfer;
      end
      if (xfer) s1_ed <= ed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_ed  <= '0;
      max_ed  <= '0;
      err_cnt <= '0;
    end else if (start_ok) begin
      sum_ed  <= '0;
      max_ed  <= '0;
      err_cnt <= '0;
    end else if (s1_valid) begin
      sum_ed  <= sum_ed + SW'(s1_ed);
      if (s1_ed > max_ed) max_ed <= s1_ed;
      err_cnt <= err_cnt + CW'(s1_ed != '0);
    end
  end

  assign mae       = sum_ed[SW-1:SAMPLES_LOG2];
  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign done      = done_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed bench for approx_err_monitor with N = 4 samples per run.
module tb_approx_err_monitor;
  import approx_mon_pkg::*;

  localparam int W  = 16;
  localparam int L  = 2;
  localparam int NS = 4;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    IN1;
  logic [W-1:0]    IN2;
  logic [W:0]      APPROX;
  logic            busy;
  logic            done;
  logic [W:0]      mae;
  logic [W:0]      max_ed;
  logic [L:0]      err_cnt;
  logic [W+L:0]    sum_ed;
  state_t          dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] s_in1 [NS];
  logic [W-1:0] s_in2 [NS];
  logic [W:0]   s_apx [NS];
  logic [31:0]  exp_q [$];

  approx_err_monitor #(.WIDTH(W), .SAMPLES_LOG2(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .IN1       (IN1),
    .IN2       (IN2),
    .APPROX    (APPROX),
    .busy      (busy),
    .done      (done),
    .mae       (mae),
    .max_ed    (max_ed),
    .err_cnt   (err_cnt),
    .sum_ed    (sum_ed),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver: sample sets with hand-computed EDs pushed to the scoreboard
  task automatic load_set(input int id);
    logic [31:0] eds [NS];
    case (id)
      0: begin
        s_in1 = '{16'h00FF, 16'hFFFF, 16'h1234, 16'hAAAA};
        s_in2 = '{16'h0001, 16'hFFFF, 16'h4321, 16'h5555};
        s_apx = '{17'h00100, 17'h1FFFE, 17'h05555, 17'h0FFFF};
        eds   = '{0, 0, 0, 0};
      end
      1: begin
        s_in1 = '{16'h0010, 16'h1234, 16'h8000, 16'h00FF};
        s_in2 = '{16'h0001, 16'h0100, 16'h8000, 16'h0001};
        s_apx = '{17'h00014, 17'h01334, 17'h0FFF8, 17'h000FB};
        eds   = '{3, 0, 8, 5};
      end
      default: begin
        s_in1 = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        s_in2 = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        s_apx = '{17'h0, 17'h0, 17'h0, 17'h0};
        eds   = '{32'h1FFFE, 32'h1FFFE, 32'h1FFFE, 32'h1FFFE};
      end
    endcase
    exp_q.delete();
    for (int i = 0; i < NS; i++) exp_q.push_back(eds[i]);
  endtask

  task automatic run(input bit toggle, input int start_pulse_at, input int abort_after,
                     output int cycles, output int xfers, output bit aborted);
    bit ph;
    bit acc;
    bit ready_chk;
    int idx;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("clear_sum", sum_ed, 0);
    check("clear_max", max_ed, 0);
    check("clear_cnt", err_cnt, 0);
    cycles = 0; xfers = 0; aborted = 1'b0; ph = 1'b1; ready_chk = 1'b0;
    for (int it = 0; it < 64; it++) begin
      if (done) break;
      if (abort_after != 0 && xfers == abort_after) begin
        aborted = 1'b1;
        break;
      end
      if (xfers == NS && !ready_chk) begin
        check("ready_low_after_n", in_ready, 0);
        ready_chk = 1'b1;
      end
      if (start_pulse_at >= 0 && cycles == start_pulse_at + 1)
        check("state_run_after_ignored_start", 32'(dbg_state), 32'(ST_RUN));
      start    = (cycles == start_pulse_at);
      in_valid = toggle ? ph : 1'b1;
      idx      = (xfers < NS) ? xfers : NS - 1;
      IN1      = s_in1[idx];
      IN2      = s_in2[idx];
      APPROX   = s_apx[idx];
      acc      = in_valid && in_ready;
      @(posedge clk);
      if (acc) xfers++;
      cycles++;
      @(negedge clk);
      ph = ~ph;
    end
    start = 1'b0;
    if (!aborted) begin
      in_valid = 1'b0;
      check("done_seen", done, 1);
    end
  endtask

  // scoreboard: fold the expected EDs and compare the final statistics
  task automatic check_results();
    logic [31:0] e_sum, e_max, e_cnt, e;
    e_sum = 0; e_max = 0; e_cnt = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      e_sum += e;
      if (e > e_max) e_max = e;
      if (e != 0) e_cnt++;
    end
    check("sum_ed", sum_ed, e_sum);
    check("mae", mae, e_sum >> L);
    check("max_ed", max_ed, e_max);
    check("err_cnt", err_cnt, e_cnt);
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_in_ready"}, in_ready, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_mae"}, mae, 0);
    check({pfx, "_max_ed"}, max_ed, 0);
    check({pfx, "_err_cnt"}, err_cnt, 0);
    check({pfx, "_sum_ed"}, sum_ed, 0);
    check({pfx, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    int  cyc, nx;
    bit  ab;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    IN1 = '0; IN2 = '0; APPROX = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // exact adder: zero statistics, done N+2 cycles after start
    load_set(0);
    run(1'b0, -1, 0, cyc, nx, ab);
    check("exact_cycles", cyc, 6);
    check_results();
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_in_done", busy, 0);
    check("state_done", 32'(dbg_state), 32'(ST_DONE));

    // known errors 3,0,8,5
    load_set(1);
    run(1'b0, -1, 0, cyc, nx, ab);
    check("known_cycles", cyc, 6);
    check_results();

    // backpressure with an ignored start pulse in RUN
    load_set(1);
    run(1'b1, 2, 0, cyc, nx, ab);
    check("bp_transfers", nx, NS);
    check("bp_cycles", cyc, 9);
    check_results();

    // restart two cycles after done with the maximum-error set
    @(negedge clk);
    load_set(2);
    run(1'b0, -1, 0, cyc, nx, ab);
    check_results();

    // reset mid-run after two accepted samples
    load_set(2);
    run(1'b0, -1, 2, cyc, nx, ab);
    check("abort_reached", ab, 1);
    check("partial_sum", sum_ed, 32'h1FFFE);
    check("partial_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_state("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_set(1);
    run(1'b0, -1, 0, cyc, nx, ab);
    check_results();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/approx_err_monitor.md
# approx_err_monitor

Streaming error-statistics stage placed directly downstream of the 16-bit approximate ripple-carry adders. It consumes operand pairs together with the adder's 17-bit result and recomputes the exact sum. Over a run of 2^SAMPLES_LOG2 accepted samples it accumulates the error distance (ED), and reports mean absolute error (MAE), maximum ED and error count. It is used in simulation and emulation to characterise each approximate adder configuration.

## Interface
- WIDTH, 16: operand width; the result width is WIDTH+1.
- SAMPLES_LOG2, 10: run length N = 2^SAMPLES_LOG2 samples.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- in_valid  in  1  a sample is present on IN1/IN2/APPROX.
- in_ready  out  1  the block accepts a sample this cycle.
- IN1, IN2  in  WIDTH  operands as driven into the adder.
- APPROX  in  WIDTH+1  approximate adder output (Out) for IN1/IN2.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when results become valid.
- mae  out  WIDTH+1  sum_ed >> SAMPLES_LOG2 (truncated).
- max_ed  out  WIDTH+1  largest ED in the run.
- err_cnt  out  SAMPLES_LOG2+1  number of samples with ED != 0.
- sum_ed  out  WIDTH+1+SAMPLES_LOG2  exact ED sum; it never overflows.

## Operation
- States:
  - IDLE (reset state)
  - RUN: accept samples.
  - DRAIN: pipeline emptying.
  - DONE: results held.
- IDLE/DONE + start → RUN. Entering RUN clears sum_ed, max_ed, err_cnt and the sample counter in the same edge.
- start while in RUN or DRAIN is ignored.
- RUN: in_ready = 1 while accepted count < N. A transfer occurs when in_valid && in_ready.
- When the Nth sample is accepted: in_ready falls the next cycle and the FSM moves to DRAIN.
- DRAIN → DONE once the stage-1 register is empty. done pulses on the DRAIN→DONE edge.
- DONE holds all result outputs until the next start. in_ready is 0 outside RUN.
- ED = |(IN1 + IN2) − APPROX|:
  - Exact sum is WIDTH+1 bits, zero-extended.
  - Compute the difference in WIDTH+2-bit signed arithmetic, then take the magnitude. The result fits in WIDTH+1 bits.
- Stage 1 (registered): ED and a valid flag.
- Stage 2 (registered), when the stage-1 flag is valid:
  - sum_ed += ED
  - max_ed = max(max_ed, ED)
  - err_cnt += (ED != 0)
- mae is combinational from sum_ed.
- Results update during RUN. They are guaranteed final only when done has pulsed.
- in_valid with X-free operands is required only when in_ready = 1; other cycles are don't-care.

## Timing
- Reset (async assert, sync deassert): IDLE; in_ready = busy = done = 0; mae = max_ed = err_cnt = sum_ed = 0; pipeline flag = 0.
- Latency from a sample's acceptance to its effect on the accumulators: 2 edges.
- Last acceptance at edge k → DRAIN at k+1 → done high in the cycle after edge k+2.
- Throughput: one sample per cycle, no bubbles required.
- Maximum run length from start to done, with in_valid held high: N+2 cycles.
- Reset asserted mid-run aborts the run immediately. Partial results are discarded and all outputs return to their reset values.
- start in the same cycle as done (DONE entry) is not honoured. start is honoured on any later cycle in DONE.

## Structure
- Shared package approx_mon_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - localparams RES_W = WIDTH+1, SUM_W = RES_W+SAMPLES_LOG2
- One sub-module: err_distance (combinational; IN1, IN2, APPROX → ED). It is reused later by the formal harness.
- The FSM, counters and accumulators live in the top module.

## Test plan
Bench setting: SAMPLES_LOG2 = 2 (N = 4), in_valid held high.
- Exact inputs: 4 samples with APPROX = IN1+IN2, e.g. 0x00FF+0x0001 → 0x00100. Required: done after 6 cycles from start; sum_ed = 0, mae = 0, max_ed = 0, err_cnt = 0.
- Known errors: EDs of 3, 0, 8, 5, e.g. IN1 = 0x0010, IN2 = 0x0001, APPROX = 0x00014 gives ED = 3. Required: sum_ed = 16, mae = 4, max_ed = 8, err_cnt = 3.
- Maximum ED: IN1 = IN2 = 0xFFFF with APPROX = 0 for all 4 samples. Required: ED = 0x1FFFE each; sum_ed = 0x7FFF8, mae = 0x1FFFE, max_ed = 0x1FFFE.
- Backpressure and ignored start: in_valid toggles 1,0,1,0…. Required: exactly 4 transfers counted, and in_ready = 0 after the 4th. A start pulse in RUN has no effect.
- Reset mid-run: assert rst_n = 0 after 2 samples. Required: all outputs 0 immediately and the state is IDLE. A fresh run after reset yields only the new run's statistics.
- Restart from DONE: issue start two cycles after done. Required: accumulators clear on entry to RUN, and the second run's results are independent of the first.
